// File: rtl/fpga_core.sv
// rtl/fpga_core.sv - 64-tile LUT fabric core with serial configuration chain; CLB_FF_EN adds tile output flip-flops
module fpga_core #(
   parameter int NTILE = 64,
   parameter int TW    = 69,
   parameter int CW    = NTILE * TW
) (
   input  logic        clb_clk,
   input  logic        rst,
   input  logic        prog_in,
   input  logic        prog_en,
   output logic        prog_out,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [31:0] in3,
   input  logic [31:0] in4,
   output logic [31:0] out1,
   output logic [31:0] out2,
   output logic [31:0] out3,
   output logic [31:0] out4
);

   // Word field offsets inside one tile's configuration slice.
   localparam int F_SEL0 = 8;
   localparam int F_SEL1 = 11;
   localparam int F_SEL2 = 14;
   localparam int F_SEL3 = 17;
   localparam int F_LUT0 = 20;
   localparam int F_LUT1 = 36;

   logic [CW-1:0]    cfg_q;
   logic [CW-1:0]    cfg_d;
   logic [NTILE-1:0] path0;
   logic [NTILE-1:0] path1;

   // Shift the chain toward bit 0 while programming; the first bit in ends up at cfg[0].
   always_comb begin
      cfg_d = cfg_q;
      if (prog_en) begin
         cfg_d = {prog_in, cfg_q[CW-1:1]};
      end
   end

   // Configuration register; reset wins over an in-progress load.
   always_ff @(posedge clb_clk) begin
      if (rst) begin
         cfg_q <= '0;
      end else begin
         cfg_q <= cfg_d;
      end
   end

   assign prog_out = cfg_q[0];

   for (genvar t = 0; t < NTILE; t++) begin : g_tile
      // Tiles 32..63 reuse the same input bit positions but feed out3/out4.
      localparam int B    = t % 32;
      localparam int P    = (B + 31) % 32;
      localparam int BASE = t * TW;

      logic [7:0]  cand;
      logic [2:0]  sel0;
      logic [2:0]  sel1;
      logic [2:0]  sel2;
      logic [2:0]  sel3;
      logic [3:0]  addr;
      logic [15:0] lut0_tbl;
      logic [15:0] lut1_tbl;
      logic        lut0_o;
      logic        lut1_o;

      // c0..c3 come from this bit position, c4..c7 from the lower neighbour (bit 0 wraps to 31).
      assign cand = {in4[P], in3[P], in2[P], in1[P], in4[B], in3[B], in2[B], in1[B]};

      assign sel0 = cfg_q[BASE+F_SEL0 +: 3];
      assign sel1 = cfg_q[BASE+F_SEL1 +: 3];
      assign sel2 = cfg_q[BASE+F_SEL2 +: 3];
      assign sel3 = cfg_q[BASE+F_SEL3 +: 3];

      assign addr = {cand[sel3], cand[sel2], cand[sel1], cand[sel0]};

      assign lut0_tbl = cfg_q[BASE+F_LUT0 +: 16];
      assign lut1_tbl = cfg_q[BASE+F_LUT1 +: 16];
      assign lut0_o   = lut0_tbl[addr];
      assign lut1_o   = lut1_tbl[addr];

`ifdef CLB_FF_EN
      logic ff0_q;
      logic ff1_q;

      // Tile flip-flops follow the LUTs every cycle except while the chain is shifting.
      always_ff @(posedge clb_clk) begin
         if (rst) begin
            ff0_q <= 1'b0;
            ff1_q <= 1'b0;
         end else if (!prog_en) begin
            ff0_q <= lut0_o;
            ff1_q <= lut1_o;
         end
      end

      assign path0[t] = cfg_q[BASE]   ? ff0_q : lut0_o;
      assign path1[t] = cfg_q[BASE+1] ? ff1_q : lut1_o;
`else
      assign path0[t] = lut0_o;
      assign path1[t] = lut1_o;
`endif
   end

   // Outputs are held low while the configuration is in flux.
   assign out1 = prog_en ? 32'h0 : path0[31:0];
   assign out2 = prog_en ? 32'h0 : path1[31:0];
   assign out3 = prog_en ? 32'h0 : path0[63:32];
   assign out4 = prog_en ? 32'h0 : path1[63:32];

endmodule

// File: tb/tb_fpga_core.sv
// tb/tb_fpga_core.sv - self-checking bench for fpga_core against a behavioural fabric model
module tb_fpga_core;
   localparam int NTILE = 64;
   localparam int TW    = 69;
   localparam int CW    = NTILE * TW;

   logic        clk;
   logic        rst;
   logic        prog_in;
   logic        prog_en;
   logic        prog_out;
   logic [31:0] in_v [4];
   logic [31:0] out1, out2, out3, out4;

   int checks;
   int errors;

   // Model state: intended configuration and tile flip-flop contents.
   logic [CW-1:0]    cfg_m;
   logic [NTILE-1:0] ff0_m;
   logic [NTILE-1:0] ff1_m;

   fpga_core dut (
      .clb_clk (clk),
      .rst     (rst),
      .prog_in (prog_in),
      .prog_en (prog_en),
      .prog_out(prog_out),
      .in1     (in_v[0]),
      .in2     (in_v[1]),
      .in3     (in_v[2]),
      .in4     (in_v[3]),
      .out1    (out1),
      .out2    (out2),
      .out3    (out3),
      .out4    (out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int field(int t, int lo, int w);
      int v;
      v = 0;
      for (int k = 0; k < w; k++) v = v + (int'(cfg_m[t*TW+lo+k]) << k);
      return v;
   endfunction

   function automatic logic lut_val(int t, int path);
      int b, p, a, s;
      logic c;
      b = t % 32;
      p = (b + 31) % 32;
      a = 0;
      for (int j = 0; j < 4; j++) begin
         s = field(t, 8 + 3*j, 3);
         c = (s < 4) ? in_v[s][b] : in_v[s-4][p];
         a = a + (int'(c) << j);
      end
      return cfg_m[t*TW + 20 + 16*path + a];
   endfunction

   function automatic logic [31:0] model_bus(int bus);
      logic [31:0] r;
      int t, path;
      logic v;
      for (int b = 0; b < 32; b++) begin
         t    = (bus >= 2 ? 32 : 0) + b;
         path = bus % 2;
         v    = lut_val(t, path);
`ifdef CLB_FF_EN
         if (cfg_m[t*TW + path]) v = (path == 1) ? ff1_m[t] : ff0_m[t];
`endif
         r[b] = prog_en ? 1'b0 : v;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_out1"}, out1, model_bus(0));
      chk({tag, "_out2"}, out2, model_bus(1));
      chk({tag, "_out3"}, out3, model_bus(2));
      chk({tag, "_out4"}, out4, model_bus(3));
   endtask

   task automatic chk_const(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic [31:0] e4);
      chk({tag, "_out1"}, out1, e1);
      chk({tag, "_out2"}, out2, e2);
      chk({tag, "_out3"}, out3, e3);
      chk({tag, "_out4"}, out4, e4);
   endtask

   // One clock edge; the model flip-flops capture with pre-edge inputs.
   task automatic step();
      logic [NTILE-1:0] n0, n1;
      n0 = ff0_m;
      n1 = ff1_m;
      if (rst) begin
         n0 = '0;
         n1 = '0;
      end else if (!prog_en) begin
         for (int t = 0; t < NTILE; t++) begin
            n0[t] = lut_val(t, 0);
            n1[t] = lut_val(t, 1);
         end
      end
      @(posedge clk);
      #1;
      ff0_m = n0;
      ff1_m = n1;
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < 4; k++) in_v[k] = $urandom;
   endtask

   task automatic set_all_inputs(input logic [31:0] v);
      for (int k = 0; k < 4; k++) in_v[k] = v;
   endtask

   task automatic set_field(input int t, input int lo, input int w, input logic [15:0] val);
      for (int k = 0; k < w; k++) cfg_m[t*TW+lo+k] = val[k];
   endtask

   task automatic load_cfg(input string tag);
      prog_en = 1'b1;
      for (int i = 0; i < CW; i++) begin
         prog_in = cfg_m[i];
         step();
         if (i == CW/2) chk_const({tag, "_midload"}, 32'h0, 32'h0, 32'h0, 32'h0);
      end
      prog_en = 1'b0;
      prog_in = 1'b0;
      #1;
      chk({tag, "_prog_out"}, {31'h0, prog_out}, {31'h0, cfg_m[0]});
   endtask

   task automatic logic_cfg(input logic w0);
      cfg_m = '0;
      for (int t = 0; t < NTILE; t++) begin
         set_field(t, 8, 12, 16'({3'b011, 3'b010, 3'b001, 3'b000}));
         set_field(t, 20, 16, 16'h8000);
         set_field(t, 36, 16, 16'h6996);
         cfg_m[t*TW] = w0;
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      prog_en = 1'b0;
      prog_in = 1'b0;
      cfg_m   = '0;
      ff0_m   = '0;
      ff1_m   = '0;
      rand_inputs();

      // Reset
      step();
      rst = 1'b0;
      rand_inputs();
      #1;
      chk_const("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      chk("reset_prog_out", {31'h0, prog_out}, 32'h0);

      // Zero load
      cfg_m = '0;
      load_cfg("zero");
      in_v[0] = 32'h12345678;
      in_v[1] = 32'hFFFFFFFF;
      in_v[2] = 32'hFFFFFFFF;
      in_v[3] = 32'hFFFFFFFF;
      #1;
      chk_const("zero", 32'h0, 32'h0, 32'h0, 32'h0);

      // Logic load, combinational paths
      logic_cfg(1'b0);
      load_cfg("logic");
      set_all_inputs(32'hFFFFFFFF);
      #1;
      chk_const("logic_ones", 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0);
      in_v[3] = 32'h0;
      #1;
      chk_const("logic_in4z", 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
      step();
      chk_model("logic_step");

      // Registered path on out1/out3
      logic_cfg(1'b1);
      set_all_inputs(32'hFFFFFFFF);
      load_cfg("reg");
      step();
      chk_const("reg_settled", 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0);
      in_v[3] = 32'h0;
      #1;
`ifdef CLB_FF_EN
      chk_const("reg_same_cycle", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
      chk_const("reg_same_cycle", 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
`endif
      step();
      chk_const("reg_next_cycle", 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
      prog_en = 1'b1;
      #1;
      chk_const("reg_prog_en", 32'h0, 32'h0, 32'h0, 32'h0);
      prog_en = 1'b0;

      // Neighbour wrap
      cfg_m = '0;
      for (int t = 0; t < 32; t++) begin
         set_field(t, 8, 3, 16'd4);
         set_field(t, 20, 16, 16'hAAAA);
      end
      load_cfg("wrap");
      set_all_inputs(32'h0);
      in_v[0] = 32'h1;
      #1;
      chk("wrap_bit0", out1, 32'h2);
      in_v[0] = 32'h80000000;
      #1;
      chk("wrap_bit31", out1, 32'h1);

      // Random configurations and inputs against the model
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < CW; i++) cfg_m[i] = ($urandom_range(1, 0) == 1);
         rand_inputs();
         load_cfg("rand_load");
         for (int v = 0; v < 8; v++) begin
            rand_inputs();
            #1;
            chk_model("rand_comb");
            step();
            chk_model("rand_step");
         end
      end

      // Chain out
      cfg_m = '0;
      cfg_m[0] = 1'b1;
      prog_en = 1'b1;
      for (int i = 0; i < CW; i++) begin
         prog_in = cfg_m[i];
         step();
      end
      chk("chain_after_cw", {31'h0, prog_out}, 32'h1);
      prog_in = 1'b0;
      step();
      chk("chain_after_cw1", {31'h0, prog_out}, 32'h0);
      prog_en = 1'b0;
      cfg_m   = '0;

      // Reset aborts a load
      for (int i = 0; i < CW; i++) cfg_m[i] = ($urandom_range(1, 0) == 1);
      prog_en = 1'b1;
      for (int i = 0; i < CW/3; i++) begin
         prog_in = cfg_m[i];
         step();
      end
      rst = 1'b1;
      step();
      rst     = 1'b0;
      prog_en = 1'b0;
      cfg_m   = '0;
      rand_inputs();
      #1;
      chk_const("abort", 32'h0, 32'h0, 32'h0, 32'h0);
      chk("abort_prog_out", {31'h0, prog_out}, 32'h0);
      step();
      chk_model("abort_step");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
